qed_dup_queue: RTL and testbench

Parametrised QED duplication queue between the fetch unit and the QED instruction mux. In ORIGINAL phase it records every non-NOP fetched instruction and forwards it. In DUPLICATE phase it replays the recorded instructions in FIFO order. It supersedes the fixed 32-entry queue with these additions:
- configurable width, depth and NOP opcode
- full-depth occupancy
- registered outputs
- a phase FSM with drain-done signalling
- overflow detection

---
 rtl/qed_dup_queue_pkg.sv | 19 +
 rtl/qed_dup_queue_if.sv | 35 +++
 rtl/qed_dup_queue_ptr_ctr.sv | 19 +
 rtl/qed_dup_queue.sv | 108 ++++++++++
 tb/tb_qed_dup_queue.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qed_dup_queue_pkg.sv
// Shared QED definitions: phase encoding and default NOP constants.
// Also used by the QED mux and decoder.
package qed_pkg;

  typedef enum logic [1:0] {
    PH_ORIG    = 2'd0,
    PH_DUP     = 2'd1,
    PH_DRAINED = 2'd2
  } qed_phase_e;

  localparam logic [6:0]  QED_NOP_OPC  = 7'h7F;
  localparam logic [31:0] QED_NOP_WORD = 32'h0000_007F;

  // True when the opcode field matches the configured NOP opcode.
  function automatic logic opc_is_nop(input logic [6:0] opc, input logic [6:0] nop_opc);
    return opc == nop_opc;
  endfunction

endpackage

// File: rtl/qed_dup_queue_if.sv
// Fetch-side / mux-side bundle of the QED duplication queue.
// Handshake: there is no back-pressure. out_vld qualifies out_inst for one
// cycle; when out_vld is low, out_inst carries the NOP word, or holds its
// last value while if_stall is high. phase is the queue FSM state for debug.
interface qed_dup_queue_if
  import qed_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic              exec_dup;
  logic              if_stall;
  logic              flush;
  logic [DATA_W-1:0] ifu_inst;
  logic [DATA_W-1:0] out_inst;
  logic              out_vld;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              dup_done;
  logic              ovf_err;
  qed_phase_e        phase;

  modport master (
    output exec_dup, if_stall, flush, ifu_inst,
    input  out_inst, out_vld, count, full, empty, dup_done, ovf_err, phase
  );

  modport slave (
    input  exec_dup, if_stall, flush, ifu_inst,
    output out_inst, out_vld, count, full, empty, dup_done, ovf_err, phase
  );
endinterface

// File: rtl/qed_dup_queue_ptr_ctr.sv
// Wrap-bit pointer counter: the low bits index storage, the MSB toggles on
// every wrap so full and empty can be told apart with all entries in use.
module qed_ptr_ctr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Clear wins over increment; natural overflow performs the wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) ptr <= '0;
    else if (inc)     ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/qed_dup_queue.sv
// QED duplication queue: records non-NOP fetched instructions during the
// ORIGINAL phase and replays them in FIFO order during the DUPLICATE phase.
module qed_dup_queue
  import qed_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 32,
  parameter logic [6:0]  NOP_OPC  = QED_NOP_OPC,
  parameter logic [31:0] NOP_WORD = QED_NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  qed_dup_queue_if.slave  q
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_WORD);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     cnt;
  logic              full_c;
  logic              empty_c;
  logic              is_nop;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              ovf;
  qed_phase_e        state;

  assign cnt     = tail - head;
  assign empty_c = (head == tail);
  assign full_c  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  assign is_nop  = opc_is_nop(q.ifu_inst[6:0], NOP_OPC);

  // A push request is a live ORIGINAL-phase instruction; it only lands if there is room.
  assign push_req = (state == PH_ORIG) && !q.exec_dup && !q.if_stall && !q.flush && !is_nop;
  assign push     = push_req && !full_c;
  assign ovf      = push_req && full_c;
  assign pop      = (state == PH_DUP) && !q.if_stall && !q.flush && !empty_c;

  assign q.count = cnt;
  assign q.full  = full_c;
  assign q.empty = empty_c;
  assign q.phase = state;

  qed_ptr_ctr #(.W(PW)) u_head (
    .clk   (clk),
    .rst   (rst),
    .clear (q.flush),
    .inc   (pop),
    .ptr   (head)
  );

  qed_ptr_ctr #(.W(PW)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .clear (q.flush),
    .inc   (push),
    .ptr   (tail)
  );

  // Storage write; phases are disjoint so a later pop never needs a bypass.
  always_ff @(posedge clk) begin
    if (push) mem[tail[AW-1:0]] <= q.ifu_inst;
  end

  // Phase FSM with registered instruction output, drain pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PH_ORIG;
      q.out_inst <= NOP_W;
      q.out_vld  <= 1'b0;
      q.dup_done <= 1'b0;
      q.ovf_err  <= 1'b0;
    end else begin
      q.dup_done <= 1'b0;
      q.out_vld  <= push || pop;
      if (!q.if_stall) begin
        if (push)     q.out_inst <= q.ifu_inst;
        else if (pop) q.out_inst <= mem[head[AW-1:0]];
        else          q.out_inst <= NOP_W;
      end
      if (ovf) q.ovf_err <= 1'b1;

      case (state)
        PH_ORIG: begin
          if (q.exec_dup) state <= PH_DUP;
        end
        PH_DUP: begin
          if (!q.exec_dup) begin
            state <= PH_ORIG;
          end else if (q.flush || empty_c || (pop && cnt == PW'(1))) begin
            state      <= PH_DRAINED;
            q.dup_done <= 1'b1;
          end
        end
        PH_DRAINED: begin
          if (!q.exec_dup) state <= PH_ORIG;
        end
        default: state <= PH_ORIG;
      endcase
    end
  end

endmodule

// File: tb/tb_qed_dup_queue.sv
// Directed bench for qed_dup_queue: a DEPTH=32 and a DEPTH=4 instance, one
// active at a time (the other is held in reset), share the stimulus signals.
module tb_qed_dup_queue;
  import qed_pkg::*;

  localparam logic [31:0] NOPW = 32'h0000_007F;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic rst_s = 1'b1;
  logic use_small = 1'b0;

  logic        exec_dup = 1'b0;
  logic        if_stall = 1'b0;
  logic        flush    = 1'b0;
  logic [31:0] ifu_inst = NOPW;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // clock
  always #5 clk = ~clk;

  qed_dup_queue_if #(.DATA_W(32), .DEPTH(32)) ifb ();
  qed_dup_queue_if #(.DATA_W(32), .DEPTH(4))  ifs ();

  assign ifb.exec_dup = exec_dup;
  assign ifb.if_stall = if_stall;
  assign ifb.flush    = flush;
  assign ifb.ifu_inst = ifu_inst;
  assign ifs.exec_dup = exec_dup;
  assign ifs.if_stall = if_stall;
  assign ifs.flush    = flush;
  assign ifs.ifu_inst = ifu_inst;

  qed_dup_queue #(.DATA_W(32), .DEPTH(32)) u_big (.clk(clk), .rst(rst_b), .q(ifb.slave));
  qed_dup_queue #(.DATA_W(32), .DEPTH(4))  u_small (.clk(clk), .rst(rst_s), .q(ifs.slave));

  logic        act_vld, act_full, act_empty, act_done, act_ovf;
  logic [31:0] act_inst, act_count, act_phase;

  always_comb begin
    act_vld   = use_small ? ifs.out_vld  : ifb.out_vld;
    act_inst  = use_small ? ifs.out_inst : ifb.out_inst;
    act_full  = use_small ? ifs.full     : ifb.full;
    act_empty = use_small ? ifs.empty    : ifb.empty;
    act_done  = use_small ? ifs.dup_done : ifb.dup_done;
    act_ovf   = use_small ? ifs.ovf_err  : ifb.ovf_err;
    act_count = use_small ? 32'(ifs.count) : 32'(ifb.count);
    act_phase = use_small ? 32'(ifs.phase) : 32'(ifb.phase);
  end

  // scoreboard monitor: every valid output must match the head of exp_q
  always @(negedge clk) begin
    if (act_vld) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_inst: unexpected output %h with no expected entry", act_inst);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (act_inst !== e) begin
          n_err++;
          $display("FAIL out_inst: got %h expected %h", act_inst, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] w, input bit expect_store);
    ifu_inst = w;
    if (expect_store) exp_q.push_back(w);
    step();
  endtask

  // Counts cycles until dup_done is seen; 0 means it never came within the budget.
  task automatic wait_done(input string name, input int exp_lat);
    int k;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (act_done) begin
        k = i;
        break;
      end
    end
    check(name, 32'(k), 32'(exp_lat));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_vld"},   32'(act_vld),   32'd0);
    check({tag, "_inst"},  act_inst,       NOPW);
    check({tag, "_count"}, act_count,      32'd0);
    check({tag, "_empty"}, 32'(act_empty), 32'd1);
    check({tag, "_full"},  32'(act_full),  32'd0);
    check({tag, "_done"},  32'(act_done),  32'd0);
    check({tag, "_ovf"},   32'(act_ovf),   32'd0);
    check({tag, "_phase"}, act_phase,      32'(PH_ORIG));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- test 1: fill with a NOP gap on DEPTH=32, then replay
    step(); step();
    check_reset("rst_big");
    rst_b = 1'b0;
    drive_word(32'h11, 1'b1);
    drive_word(32'h12, 1'b1);
    drive_word(NOPW,   1'b0);
    check("nop_vld",  32'(act_vld), 32'd0);
    check("nop_inst", act_inst, NOPW);
    drive_word(32'h13, 1'b1);
    drive_word(32'h14, 1'b1);
    drive_word(32'h15, 1'b1);
    ifu_inst = NOPW;
    check("fill_count", act_count, 32'd5);
    exec_dup = 1'b1;
    for (int i = 1; i <= 5; i++) exp_q.push_back(32'(8'h10 + i));
    step();
    check("dup_lat1_vld", 32'(act_vld), 32'd0);
    check("dup_phase",    act_phase, 32'(PH_DUP));
    step();
    check("dup_lat2_vld", 32'(act_vld), 32'd1);
    wait_done("t1_done_lat", 4);
    check("t1_drained", act_phase, 32'(PH_DRAINED));
    check("t1_empty",   32'(act_empty), 32'd1);
    step();
    check("t1_done_pulse", 32'(act_done), 32'd0);
    exec_dup = 1'b0;
    step();
    check("t1_back_orig", act_phase, 32'(PH_ORIG));

    // ---- test 2: overflow on DEPTH=4
    use_small = 1'b1;
    rst_b = 1'b1;
    step(); step();
    check_reset("rst_small");
    rst_s = 1'b0;
    drive_word(32'hA1, 1'b1);
    drive_word(32'hA2, 1'b1);
    drive_word(32'hA3, 1'b1);
    drive_word(32'hA4, 1'b1);
    drive_word(32'hA5, 1'b0);
    ifu_inst = NOPW;
    check("ovf_count", act_count, 32'd4);
    check("ovf_full",  32'(act_full), 32'd1);
    check("ovf_err",   32'(act_ovf), 32'd1);
    check("ovf_vld",   32'(act_vld), 32'd0);
    exec_dup = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(8'hA0 + i));
    wait_done("t2_done_lat", 5);
    check("t2_count", act_count, 32'd0);
    check("t2_ovf_sticky", 32'(act_ovf), 32'd1);
    exec_dup = 1'b0;
    step();

    // ---- test 3: stall mid-replay
    drive_word(32'hB1, 1'b1);
    drive_word(32'hB2, 1'b1);
    drive_word(32'hB3, 1'b1);
    drive_word(32'hB4, 1'b1);
    ifu_inst = NOPW;
    exec_dup = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(8'hB0 + i));
    step();
    step();
    if_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_vld",   32'(act_vld), 32'd0);
      check("stall_count", act_count, 32'd3);
    end
    if_stall = 1'b0;
    wait_done("t3_done_lat", 3);
    exec_dup = 1'b0;
    step();

    // ---- test 4: three rounds of 3 push / 3 pop across pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int j = 1; j <= 3; j++) drive_word(32'hC00 + 32'(r * 16 + j), 1'b1);
      ifu_inst = NOPW;
      exec_dup = 1'b1;
      for (int j = 1; j <= 3; j++) exp_q.push_back(32'hC00 + 32'(r * 16 + j));
      wait_done("t4_done_lat", 4);
      check("t4_count", act_count, 32'd0);
      check("t4_empty", 32'(act_empty), 32'd1);
      exec_dup = 1'b0;
      step();
    end

    // ---- test 5: flush in DUP with two entries
    drive_word(32'hD1, 1'b0);
    drive_word(32'hD2, 1'b0);
    // D1/D2 appear on out_inst while being recorded; expect them now
    ifu_inst = NOPW;
    exec_dup = 1'b1;
    step();
    check("t5_pre_count", act_count, 32'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_count", act_count, 32'd0);
    check("t5_done",  32'(act_done), 32'd1);
    check("t5_phase", act_phase, 32'(PH_DRAINED));
    check("t5_vld",   32'(act_vld), 32'd0);
    exec_dup = 1'b0;
    step();
    check("t5_orig", act_phase, 32'(PH_ORIG));

    // ---- test 6: reset mid-replay
    drive_word(32'hE1, 1'b1);
    drive_word(32'hE2, 1'b1);
    drive_word(32'hE3, 1'b1);
    ifu_inst = NOPW;
    exec_dup = 1'b1;
    exp_q.push_back(32'hE1);
    step();
    step();
    rst_s = 1'b1;
    step();
    check_reset("rst_mid");
    rst_s = 1'b0;
    exec_dup = 1'b0;
    step(); step();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // D1/D2 in test 5 are forwarded during fill; push their expectations
  // at the moment they are driven.
  always @(posedge clk) begin
    if (!rst_s && use_small && !exec_dup && !if_stall && !flush &&
        (ifu_inst == 32'hD1 || ifu_inst == 32'hD2))
      exp_q.push_back(ifu_inst);
  end

endmodule
